wb_bus_master: RTL and testbench
================================

# wb_bus_master

Downstream bus stage of the memory controller. Accepts one read or write request at a time and runs it as a Wishbone-classic single transfer on the system bus. Returns read data, a one-cycle completion pulse, and the `bus_full` busy indication that the memory controller already consumes. A programmable ack timeout prevents a dead slave from hanging the core.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of BUSY cycles to wait for `ack_i`; 0 disables the timeout.
- `clk` input 1: system clock; all state changes on rising edge.
- `rst` input 1: reset; asynchronous, active-low.
- `read_req` input 1: read request, sampled only in IDLE.
- `write_req` input 1: write request, sampled only in IDLE.
- `addr_in` input 32: byte address of the request.
- `wdata_in` input 32: write data.
- `sel_in` input 4: byte lane enables.
- `bus_full` output 1: block busy; new requests are ignored while high.
- `rdata_out` output 32: last successfully read word.
- `done` output 1: one-cycle pulse when a transfer completes (ack or timeout).
- `err` output 1: one-cycle pulse, coincident with `done`, on timeout.
- `adr_o` output 32, `dat_o` output 32, `sel_o` output 4, `we_o` output 1, `cyc_o` output 1, `stb_o` output 1: Wishbone master outputs.
- `dat_i` input 32, `ack_i` input 1: Wishbone slave responses.

## Operation
- States: IDLE, BUSY, RESP.
- **IDLE.** `bus_full` is 0 and `cyc_o`/`stb_o` are 0.
  - If `read_req` is 1 at a rising edge: latch `addr_in` and `sel_in`, set `we_o`=0, clear the timeout counter, go to BUSY.
  - Otherwise, if `write_req` is 1: also latch `wdata_in`, set `we_o`=1, go to BUSY.
  - If both are 1, the read wins and the write is dropped. The requester must re-issue it.
- **BUSY.** `cyc_o`=`stb_o`=1; `adr_o`/`dat_o`/`sel_o`/`we_o` are held at the latched values.
  - If `ack_i` is 1 at an edge: for a read, capture `dat_i` into `rdata_out`; go to RESP with the error flag clear.
  - Else, if `TIMEOUT_CYCLES`≠0 and the counter equals `TIMEOUT_CYCLES`-1: go to RESP with the error flag set.
  - Else: increment the counter.
- **RESP.** `cyc_o`=`stb_o`=0, `done`=1, `err` = error flag, `bus_full`=1. Next edge returns to IDLE.
- `bus_full` = (state ≠ IDLE), decoded from registered state. All bus outputs are registered.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1. It saturates and never wraps.
- On timeout, `rdata_out` keeps its previous value.
- `ack_i` outside BUSY is ignored.
- Requests while `bus_full`=1 are ignored; there is no queuing.
- `adr_o`/`dat_o`/`sel_o` keep their last values in IDLE. `we_o` returns to 0 in IDLE.

## Timing
- **Reset values** (when `rst`=0, immediate and asynchronous):
  - State IDLE, counter 0.
  - `bus_full`, `done`, `err`, `cyc_o`, `stb_o`, `we_o` = 0.
  - `adr_o`, `dat_o`, `sel_o`, `rdata_out` = 0.
- Reset mid-transfer aborts the cycle: `cyc_o` drops without waiting for `ack_i`, and no `done` is produced.
- **Request accepted at edge E:**
  - `cyc_o`/`stb_o`/`bus_full` are high from E.
  - With `ack_i` high in the first BUSY cycle, the ack is sampled at E+1. `done` and `rdata_out` are valid after E+1, and `bus_full` is low after E+2.
  - Each wait state adds one cycle.
- Back-to-back throughput with zero-wait slaves is one transfer per 3 cycles.
- **Timeout:** with no ack, `done`/`err` assert after edge E+`TIMEOUT_CYCLES`, and `cyc_o` is high for exactly `TIMEOUT_CYCLES` cycles.
- **Boundary case:** if `ack_i` arrives in the same cycle the counter expires, the ack wins (`err`=0, data captured).

## Test plan
- **Reset:** hold `rst`=0 with `read_req`=1 and `ack_i`=1 for 2 cycles → all outputs 0, state IDLE. Release → read accepted on the next edge.
- **Zero-wait read:**
  - Stimulus: `read_req`=1, `addr_in`=0x0000_0040, `sel_in`=0xF; slave acks in the first cycle with `dat_i`=0xDEAD_BEEF.
  - Response: `cyc_o` high for 1 cycle, `adr_o`=0x40, `we_o`=0; `done`=1 and `rdata_out`=0xDEAD_BEEF in the next cycle; `bus_full` high for exactly 2 cycles.
- **Write with 3 wait states:**
  - Stimulus: `write_req`=1, `addr_in`=0x100, `wdata_in`=0x1234_5678, `sel_in`=0x3; ack on the 4th BUSY cycle.
  - Response: `cyc_o` high 4 cycles, `we_o`=1, `dat_o`=0x1234_5678 stable throughout; `done` pulse with `err`=0; `rdata_out` unchanged.
- **Read/write collision:** `read_req`=`write_req`=1 in IDLE → `we_o`=0 and only a read is performed. Keep `write_req` high during BUSY → it is ignored until IDLE, then the write runs.
- **Timeout:**
  - Stimulus: `TIMEOUT_CYCLES`=4, read with `ack_i` tied 0.
  - Response: `cyc_o` high exactly 4 cycles, then `done`=`err`=1 for one cycle; `rdata_out` keeps its prior value; the next read with ack succeeds with `err`=0.
- **Mid-operation reset and stray ack:**
  - Assert `rst`=0 during the 2nd BUSY cycle → `cyc_o`/`bus_full` drop immediately and no `done` appears.
  - Pulse `ack_i` while IDLE → no state change.

Source files
------------

// File: rtl/wb_bus_master.sv
// Wishbone-classic single-transfer bus master for the memory controller.
// One request at a time, with an optional ack timeout that reports an error.
module wb_bus_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_req,
  input  logic        write_req,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic [3:0]  sel_in,
  output logic        bus_full,
  output logic [31:0] rdata_out,
  output logic        done,
  output logic        err,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o,
  output logic        we_o,
  output logic        cyc_o,
  output logic        stb_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i
);

  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic            r_err;
  logic            w_expire;

  assign w_expire = TO_EN && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (read_req || write_req) w_state_nxt = ST_BUSY;
      ST_BUSY: if (ack_i || w_expire)     w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request latching, read capture and wait-state counting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adr_o     <= '0;
      dat_o     <= '0;
      sel_o     <= '0;
      we_o      <= 1'b0;
      rdata_out <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (read_req) begin
            adr_o <= addr_in;
            sel_o <= sel_in;
            we_o  <= 1'b0;
            r_cnt <= '0;
          end else if (write_req) begin
            adr_o <= addr_in;
            sel_o <= sel_in;
            dat_o <= wdata_in;
            we_o  <= 1'b1;
            r_cnt <= '0;
          end
        end
        ST_BUSY: begin
          if (ack_i) begin
            if (!we_o) rdata_out <= dat_i;
            r_err <= 1'b0;
          end else if (w_expire) begin
            r_err <= 1'b1;
          end else if (!(&r_cnt)) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: we_o <= 1'b0;
        default: we_o <= 1'b0;
      endcase
    end
  end

  // Handshake and status outputs decode straight from the state register
  assign bus_full = (r_state != ST_IDLE);
  assign cyc_o    = (r_state == ST_BUSY);
  assign stb_o    = (r_state == ST_BUSY);
  assign done     = (r_state == ST_RESP);
  assign err      = (r_state == ST_RESP) && r_err;

endmodule

// File: tb/tb_wb_bus_master.sv
// Randomised bench for wb_bus_master: a transaction-level timeline model sets the
// expected outputs each cycle and one negedge process compares them.
module tb_wb_bus_master;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_req, write_req, ack_i;
  logic [31:0] addr_in, wdata_in, dat_i;
  logic [3:0]  sel_in;
  logic        bus_full, done, err, we_o, cyc_o, stb_o;
  logic [31:0] rdata_out, adr_o, dat_o;
  logic [3:0]  sel_o;

  int checks = 0;
  int errors = 0;

  logic        exp_bf, exp_done, exp_err, exp_cyc, exp_we;
  logic [31:0] exp_adr, exp_dat, exp_rdata;
  logic [3:0]  exp_sel;
  bit          we_care = 1'b1;
  bit          chk_en = 1'b0;
  int          cyc_hi_cnt, bf_hi_cnt, done_cnt, err_cnt;

  wb_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .read_req(read_req), .write_req(write_req),
    .addr_in(addr_in), .wdata_in(wdata_in), .sel_in(sel_in),
    .bus_full(bus_full), .rdata_out(rdata_out), .done(done), .err(err),
    .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o),
    .cyc_o(cyc_o), .stb_o(stb_o),
    .dat_i(dat_i), .ack_i(ack_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    exp_bf = 0; exp_done = 0; exp_err = 0; exp_cyc = 0; exp_we = 0; we_care = 1;
    exp_adr = '0; exp_dat = '0; exp_sel = '0; exp_rdata = '0;
  endtask

  task automatic clr_cnt();
    cyc_hi_cnt = 0; bf_hi_cnt = 0; done_cnt = 0; err_cnt = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("bus_full",  32'(bus_full),  32'(exp_bf));
      chk("done",      32'(done),      32'(exp_done));
      chk("err",       32'(err),       32'(exp_err));
      chk("cyc_o",     32'(cyc_o),     32'(exp_cyc));
      chk("stb_o",     32'(stb_o),     32'(exp_cyc));
      chk("adr_o",     adr_o,          exp_adr);
      chk("dat_o",     dat_o,          exp_dat);
      chk("sel_o",     32'(sel_o),     32'(exp_sel));
      chk("rdata_out", rdata_out,      exp_rdata);
      if (we_care) chk("we_o", 32'(we_o), 32'(exp_we));
      if (cyc_o)    cyc_hi_cnt++;
      if (bus_full) bf_hi_cnt++;
      if (done)     done_cnt++;
      if (err)      err_cnt++;
    end
  end

  task automatic idle_cycle(input bit stray);
    read_req = 0; write_req = 0;
    ack_i = stray ? 1'($urandom_range(0, 1)) : 1'b0;
    dat_i = $urandom;
    @(posedge clk); #1;
    ack_i = 0;
  endtask

  // waits = wait states before ack; waits >= TO means the slave never acks
  task automatic xfer(input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] s, input int waits,
                      input logic [31:0] rdat, input bit hold_wr);
    bit acked;
    int nbusy;
    read_req = rd; write_req = wr; addr_in = a; wdata_in = wd; sel_in = s;
    ack_i = 1'($urandom_range(0, 1));
    dat_i = $urandom;
    @(posedge clk); #1;
    if (!rd && !wr) begin
      ack_i = 0;
      return;
    end
    acked = (waits < TO);
    nbusy = acked ? waits + 1 : TO;
    exp_bf = 1; exp_cyc = 1; exp_adr = a; exp_sel = s; exp_we = !rd; we_care = 1;
    if (!rd) exp_dat = wd;
    for (int k = 0; k < nbusy; k++) begin
      read_req  = hold_wr ? 1'b0 : 1'($urandom_range(0, 1));
      write_req = hold_wr ? 1'b1 : 1'($urandom_range(0, 1));
      addr_in = $urandom; wdata_in = $urandom; sel_in = 4'($urandom);
      ack_i = acked && (k == waits);
      dat_i = (k == waits) ? rdat : $urandom;
      @(posedge clk); #1;
    end
    exp_cyc = 0; exp_done = 1; exp_err = !acked; we_care = 0;
    if (acked && rd) exp_rdata = rdat;
    ack_i = 1'($urandom_range(0, 1)); dat_i = $urandom;
    read_req  = hold_wr ? 1'b0 : 1'($urandom_range(0, 1));
    write_req = hold_wr ? 1'b1 : 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    exp_bf = 0; exp_done = 0; exp_err = 0; exp_we = 0; we_care = 1;
    read_req = 0; write_req = hold_wr; ack_i = 0;
  endtask

  initial begin
    rst = 0; read_req = 1; write_req = 0; ack_i = 1;
    addr_in = 32'h40; wdata_in = '0; sel_in = 4'hF; dat_i = 32'hDEADBEEF;
    model_reset();
    clr_cnt();
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;

    // Zero-wait read straight out of reset
    clr_cnt();
    xfer(1, 0, 32'h40, 32'h0, 4'hF, 0, 32'hDEADBEEF, 0);
    chk("zw_bus_full_cycles", 32'(bf_hi_cnt), 32'd2);
    chk("zw_cyc_cycles", 32'(cyc_hi_cnt), 32'd1);
    chk("zw_done_pulses", 32'(done_cnt), 32'd1);
    chk("zw_rdata", rdata_out, 32'hDEADBEEF);
    chk("zw_adr", adr_o, 32'h40);

    // Write, 3 wait states (ack lands on the last counter value: ack must win)
    clr_cnt();
    xfer(0, 1, 32'h100, 32'h12345678, 4'h3, 3, $urandom, 0);
    chk("w3_cyc_cycles", 32'(cyc_hi_cnt), 32'd4);
    chk("w3_done_pulses", 32'(done_cnt), 32'd1);
    chk("w3_err_pulses", 32'(err_cnt), 32'd0);
    chk("w3_rdata_kept", rdata_out, 32'hDEADBEEF);
    chk("w3_dat_o", dat_o, 32'h12345678);

    // Collision: read wins, write held through BUSY then runs
    xfer(1, 1, 32'h200, 32'hAAAA5555, 4'hF, 1, 32'hCAFEF00D, 1);
    chk("col_rdata", rdata_out, 32'hCAFEF00D);
    chk("col_dat_o_untouched", dat_o, 32'h12345678);
    xfer(0, 1, 32'h300, 32'h0BADF00D, 4'h1, 0, $urandom, 0);
    chk("col_write_dat", dat_o, 32'h0BADF00D);

    // Timeout with no ack, then a clean read
    clr_cnt();
    xfer(1, 0, 32'h400, 32'h0, 4'hF, 50, 32'h11111111, 0);
    chk("to_cyc_cycles", 32'(cyc_hi_cnt), 32'd4);
    chk("to_err_pulses", 32'(err_cnt), 32'd1);
    chk("to_done_pulses", 32'(done_cnt), 32'd1);
    chk("to_rdata_kept", rdata_out, 32'hCAFEF00D);
    clr_cnt();
    xfer(1, 0, 32'h404, 32'h0, 4'hF, 2, 32'h22222222, 0);
    chk("after_to_err", 32'(err_cnt), 32'd0);
    chk("after_to_rdata", rdata_out, 32'h22222222);

    // Reset during the second BUSY cycle
    read_req = 1; addr_in = 32'h500; sel_in = 4'h7; ack_i = 0;
    @(posedge clk); #1;
    read_req = 0;
    exp_bf = 1; exp_cyc = 1; exp_adr = 32'h500; exp_sel = 4'h7; exp_we = 0;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    #1;
    chk("rst_cyc_drop", 32'(cyc_o), 32'd0);
    chk("rst_bf_drop", 32'(bus_full), 32'd0);
    clr_cnt();
    ack_i = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1; ack_i = 0;
    repeat (3) idle_cycle(1);
    chk("rst_no_done", 32'(done_cnt), 32'd0);

    // Randomised traffic with stray acks between transfers
    for (int n = 0; n < 60; n++) begin
      int r;
      r = int'($urandom_range(0, 7));
      xfer(r[0] | (r == 6), r[1] | (r == 6), $urandom, $urandom, 4'($urandom),
           int'($urandom_range(0, 6)), $urandom, 0);
      repeat ($urandom_range(0, 2)) idle_cycle(1);
    end
    idle_cycle(0);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
